// File: rtl/mii_tx_arbiter_pkg.sv
// Shared definitions for the MII transmit arbiter: FSM encoding, default
// timing constants and the requester index map.
package mii_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int IFG_CYCLES_DEFAULT       = 24;
    localparam int MAX_FRAME_CYCLES_DEFAULT = 3100;
    localparam int START_TIMEOUT_DEFAULT    = 64;

    localparam int REQ_ARP  = 0;
    localparam int REQ_DATA = 1;

    localparam int GRANT_W = 3;
    localparam int CNT_W   = 16;

    // Width of an index into a vector of n requesters (never less than 1).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational winner select: fixed priority (lowest index) or round-robin
// starting strictly after the last granted index.
module rr_grant_select
    import mii_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    input  logic               rr_mode,
    output logic [GRANT_W-1:0] grant,
    output logic               valid
);

    localparam int IW = idx_width(NUM_REQ);

    always_comb begin : select
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        // Scan order is rotated by the pointer in round-robin mode, so the
        // previous winner is checked last.
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = rr_mode ? ((int'(ptr) + 1 + off) % NUM_REQ) : off;
            if (!valid && req[IW'(idx)]) begin
                valid = 1'b1;
                grant = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mii_tx_arbiter.sv
// Shares one MII transmit port between several frame formers: grants one
// former at a time, forwards its nibbles with one clock of latency, then
// enforces the inter-frame gap. Stuck or silent formers are aborted.
module mii_tx_arbiter
    import mii_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ          = 2,
    parameter int RR_MODE          = 1,
    parameter int IFG_CYCLES       = IFG_CYCLES_DEFAULT,
    parameter int START_TIMEOUT    = START_TIMEOUT_DEFAULT,
    parameter int MAX_FRAME_CYCLES = MAX_FRAME_CYCLES_DEFAULT
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   ena,
    input  logic [NUM_REQ-1:0]   src_tx_en,
    input  logic [4*NUM_REQ-1:0] src_tx_d,
    output logic                 TX_EN,
    output logic [3:0]           TX_D,
    output logic                 busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 err_timeout,
    output state_t               fsm_state
);

    localparam int IW = idx_width(NUM_REQ);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_MAX  = CNT_W'(MAX_FRAME_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST   =
        (IFG_CYCLES > 0) ? CNT_W'(IFG_CYCLES - 1) : '0;

    // Handshake: a former holds req high until it sees its one-cycle ena
    // pulse; it then drives src_tx_en/src_tx_d as a contiguous nibble burst
    // and the arbiter forwards it until src_tx_en first drops.

    state_t             state;
    logic [GRANT_W-1:0] ptr;
    logic [CNT_W-1:0]   cnt;

    logic [GRANT_W-1:0] win;
    logic               win_valid;

    logic [3:0]         nib [NUM_REQ];
    logic               sel_en;
    logic [3:0]         sel_d;

    rr_grant_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .req     (req),
        .ptr     (ptr),
        .rr_mode (RR_MODE != 0),
        .grant   (win),
        .valid   (win_valid)
    );

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_nib
        assign nib[k] = src_tx_d[4*k +: 4];
    end

    // Only the granted former is ever looked at.
    assign sel_en = src_tx_en[IW'(grant_id)];
    assign sel_d  = nib[IW'(grant_id)];

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (sclr) begin
            state       <= ST_IDLE;
            ptr         <= GRANT_W'(NUM_REQ - 1);
            cnt         <= '0;
            ena         <= '0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            TX_EN       <= 1'b0;
            TX_D        <= 4'h0;
        end else begin
            ena         <= '0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    TX_EN <= 1'b0;
                    TX_D  <= 4'h0;
                    if (win_valid) begin
                        grant_id      <= win;
                        ptr           <= win;
                        ena[IW'(win)] <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    if (sel_en) begin
                        TX_EN <= 1'b1;
                        TX_D  <= sel_d;
                        cnt   <= CNT_W'(1);
                        state <= ST_SEND;
                    end else if (cnt == START_LAST) begin
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    // cnt holds the number of nibbles already on the pins.
                    if (!sel_en) begin
                        TX_EN <= 1'b0;
                        TX_D  <= 4'h0;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else if (cnt == FRAME_MAX) begin
                        TX_EN       <= 1'b0;
                        TX_D        <= 4'h0;
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_GAP;
                    end else begin
                        TX_EN <= 1'b1;
                        TX_D  <= sel_d;
                        cnt   <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    TX_EN <= 1'b0;
                    TX_D  <= 4'h0;
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    TX_EN <= 1'b0;
                    TX_D  <= 4'h0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Directed bench for mii_tx_arbiter: a round-robin instance with default
// timing, a fixed-priority instance with no gap, and the winner-select block.
module tb_mii_tx_arbiter;
    import mii_tx_arbiter_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic sclr;

    logic [1:0] req_a, ena_a, src_en_a;
    logic [7:0] src_d_a;
    logic       tx_en_a, busy_a, err_a;
    logic [3:0] tx_d_a;
    logic [2:0] gid_a;
    state_t     st_a;

    logic [1:0] req_b, ena_b, src_en_b;
    logic [7:0] src_d_b;
    logic       tx_en_b, busy_b, err_b;
    logic [3:0] tx_d_b;
    logic [2:0] gid_b;
    state_t     st_b;

    logic [3:0] sel_req;
    logic [2:0] sel_ptr;
    logic       sel_mode;
    logic [2:0] sel_grant;
    logic       sel_valid;

    int n_vec = 0;
    int n_err = 0;

    mii_tx_arbiter #(
        .NUM_REQ(2), .RR_MODE(1), .IFG_CYCLES(24),
        .START_TIMEOUT(64), .MAX_FRAME_CYCLES(3100)
    ) dut (
        .clock(clock), .sclr(sclr), .req(req_a), .ena(ena_a),
        .src_tx_en(src_en_a), .src_tx_d(src_d_a), .TX_EN(tx_en_a),
        .TX_D(tx_d_a), .busy(busy_a), .grant_id(gid_a),
        .err_timeout(err_a), .fsm_state(st_a)
    );

    mii_tx_arbiter #(
        .NUM_REQ(2), .RR_MODE(0), .IFG_CYCLES(0),
        .START_TIMEOUT(64), .MAX_FRAME_CYCLES(3100)
    ) dut_fp (
        .clock(clock), .sclr(sclr), .req(req_b), .ena(ena_b),
        .src_tx_en(src_en_b), .src_tx_d(src_d_b), .TX_EN(tx_en_b),
        .TX_D(tx_d_b), .busy(busy_b), .grant_id(gid_b),
        .err_timeout(err_b), .fsm_state(st_b)
    );

    rr_grant_select #(.NUM_REQ(4)) u_sel (
        .req(sel_req), .ptr(sel_ptr), .rr_mode(sel_mode),
        .grant(sel_grant), .valid(sel_valid)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        sclr = 1'b1;
        req_a = '0; src_en_a = '0; src_d_a = '0;
        req_b = '0; src_en_b = '0; src_d_b = '0;
        tick();
        tick();
        sclr = 1'b0;
    endtask

    task automatic test_grant_select();
        logic [3:0] v_req   [8] = '{4'b0000, 4'b0110, 4'b0110, 4'b0110,
                                    4'b1001, 4'b1001, 4'b0001, 4'b1000};
        logic [2:0] v_ptr   [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0};
        logic       v_mode  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] v_grant [8] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd3, 3'd0, 3'd3};
        logic       v_valid [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            sel_req = v_req[i]; sel_ptr = v_ptr[i]; sel_mode = v_mode[i];
            #1;
            n_vec++;
            if (sel_valid !== v_valid[i]) begin
                n_err++;
                $display("FAIL sel_valid[%0d]: got %b want %b", i, sel_valid, v_valid[i]);
            end
            n_vec++;
            if (sel_grant !== v_grant[i]) begin
                n_err++;
                $display("FAIL sel_grant[%0d]: got %0d want %0d", i, sel_grant, v_grant[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (ena_a !== 2'b00 || ena_b !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ena: got %b/%b want 00/00", ena_a, ena_b);
        end
        n_vec++;
        if (tx_en_a !== 1'b0 || tx_d_a !== 4'h0) begin
            n_err++;
            $display("FAIL reset_tx: got en=%b d=%h want en=0 d=0", tx_en_a, tx_d_a);
        end
        n_vec++;
        if (busy_a !== 1'b0 || gid_a !== 3'd0 || err_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: got busy=%b gid=%0d err=%b want 0/0/0",
                     busy_a, gid_a, err_a);
        end
        n_vec++;
        if (st_a !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d want %0d", st_a, ST_IDLE);
        end
    endtask

    task automatic test_single_frame();
        int k;
        do_reset();
        req_a = 2'b01;
        tick();
        n_vec++;
        if (ena_a !== 2'b01 || gid_a !== 3'(REQ_ARP)) begin
            n_err++;
            $display("FAIL single_grant: got ena=%b gid=%0d want ena=01 gid=0", ena_a, gid_a);
        end
        req_a = 2'b00;
        tick();
        n_vec++;
        if (ena_a !== 2'b00 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL single_ena_pulse: got ena=%b busy=%b want ena=00 busy=1", ena_a, busy_a);
        end
        tick();
        n_vec++;
        if (tx_en_a !== 1'b0) begin
            n_err++;
            $display("FAIL single_pre_tx: got %b want 0", tx_en_a);
        end
        for (int i = 0; i < 10; i++) begin
            src_en_a = 2'b01;
            src_d_a  = {4'h0, 4'(i + 1)};
            tick();
            n_vec++;
            if (tx_en_a !== 1'b1 || tx_d_a !== 4'(i + 1)) begin
                n_err++;
                $display("FAIL single_nibble[%0d]: got en=%b d=%h want en=1 d=%h",
                         i, tx_en_a, tx_d_a, 4'(i + 1));
            end
        end
        src_en_a = 2'b00;
        src_d_a  = 8'h00;
        tick();
        n_vec++;
        if (tx_en_a !== 1'b0 || tx_d_a !== 4'h0) begin
            n_err++;
            $display("FAIL single_end: got en=%b d=%h want en=0 d=0", tx_en_a, tx_d_a);
        end
        k = 0;
        while (busy_a === 1'b1 && k < 100) begin
            tick();
            k++;
        end
        n_vec++;
        if (k !== 24) begin
            n_err++;
            $display("FAIL single_gap: busy fell after %0d clocks want 24", k);
        end
    endtask

    task automatic test_isolation();
        do_reset();
        req_a = 2'b01;
        tick();
        req_a = 2'b00;
        src_d_a = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            src_en_a = {~src_en_a[1], 1'b0};
            tick();
            n_vec++;
            if (tx_en_a !== 1'b0) begin
                n_err++;
                $display("FAIL iso_start[%0d]: got en=%b want 0", i, tx_en_a);
            end
        end
        for (int i = 0; i < 6; i++) begin
            src_en_a = {~src_en_a[1], 1'b1};
            src_d_a  = {4'hF, 4'(i + 2)};
            tick();
            n_vec++;
            if (tx_en_a !== 1'b1 || tx_d_a !== 4'(i + 2)) begin
                n_err++;
                $display("FAIL iso_nibble[%0d]: got en=%b d=%h want en=1 d=%h",
                         i, tx_en_a, tx_d_a, 4'(i + 2));
            end
        end
        src_en_a = 2'b10;
        tick();
        n_vec++;
        if (tx_en_a !== 1'b0 || tx_d_a !== 4'h0) begin
            n_err++;
            $display("FAIL iso_end: got en=%b d=%h want en=0 d=0", tx_en_a, tx_d_a);
        end
        src_en_a = 2'b00;
    endtask

    task automatic test_round_robin();
        int k;
        logic [1:0] exp_oh;
        logic [3:0] nib;
        do_reset();
        req_a = 2'b11;
        for (int f = 0; f < 4; f++) begin
            exp_oh = (f % 2 == 1) ? 2'b10 : 2'b01;
            k = 0;
            while (ena_a === 2'b00 && k < 100) begin
                tick();
                k++;
            end
            n_vec++;
            if (ena_a !== exp_oh || gid_a !== 3'(f % 2)) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got ena=%b gid=%0d want ena=%b gid=%0d",
                         f, ena_a, gid_a, exp_oh, f % 2);
            end
            for (int i = 0; i < 8; i++) begin
                nib      = 4'(f * 3 + i);
                src_en_a = exp_oh;
                src_d_a  = {nib, nib};
                tick();
                n_vec++;
                if (tx_en_a !== 1'b1 || tx_d_a !== nib) begin
                    n_err++;
                    $display("FAIL rr_nibble[%0d.%0d]: got en=%b d=%h want en=1 d=%h",
                             f, i, tx_en_a, tx_d_a, nib);
                end
            end
            src_en_a = 2'b00;
            src_d_a  = 8'h00;
            tick();
            k = 0;
            while (busy_a === 1'b1 && k < 100) begin
                tick();
                k++;
            end
            n_vec++;
            if (k !== 24) begin
                n_err++;
                $display("FAIL rr_gap[%0d]: gap of %0d clocks want 24", f, k);
            end
        end
        req_a = 2'b00;
    endtask

    task automatic test_fixed_priority();
        int k;
        do_reset();
        req_b = 2'b11;
        for (int f = 0; f < 3; f++) begin
            k = 0;
            while (ena_b === 2'b00 && k < 100) begin
                tick();
                k++;
            end
            n_vec++;
            if (ena_b !== 2'b01 || gid_b !== 3'd0) begin
                n_err++;
                $display("FAIL fp_grant[%0d]: got ena=%b gid=%0d want ena=01 gid=0",
                         f, ena_b, gid_b);
            end
            for (int i = 0; i < 4; i++) begin
                src_en_b = 2'b11;
                src_d_b  = {4'hF, 4'(i + 5)};
                tick();
                n_vec++;
                if (tx_en_b !== 1'b1 || tx_d_b !== 4'(i + 5)) begin
                    n_err++;
                    $display("FAIL fp_nibble[%0d.%0d]: got en=%b d=%h want en=1 d=%h",
                             f, i, tx_en_b, tx_d_b, 4'(i + 5));
                end
            end
            src_en_b = 2'b00;
            src_d_b  = 8'h00;
            tick();
            k = 0;
            while (busy_b === 1'b1 && k < 100) begin
                tick();
                k++;
            end
            // With no inter-frame gap the GAP state lasts a single clock.
            n_vec++;
            if (k !== 1) begin
                n_err++;
                $display("FAIL fp_gap[%0d]: busy fell after %0d clocks want 1", f, k);
            end
        end
        req_b = 2'b00;
    endtask

    task automatic test_start_timeout();
        int k;
        int bad;
        do_reset();
        req_a = 2'b01;
        tick();
        req_a = 2'b00;
        k = 0;
        bad = 0;
        while (err_a !== 1'b1 && k < 200) begin
            tick();
            k++;
            if (tx_en_a !== 1'b0) bad++;
        end
        n_vec++;
        if (k !== 64) begin
            n_err++;
            $display("FAIL to_latency: err after %0d clocks want 64", k);
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL to_silent: TX_EN high %0d clocks want 0", bad);
        end
        tick();
        n_vec++;
        if (err_a !== 1'b0) begin
            n_err++;
            $display("FAIL to_pulse: got err=%b want 0", err_a);
        end
        req_a = 2'b10;
        k = 0;
        while (ena_a === 2'b00 && k < 100) begin
            tick();
            k++;
        end
        // The err pulse clock is gap clock 0; the grant follows 23 more gap
        // clocks and one IDLE decision clock.
        n_vec++;
        if (k !== 24 || ena_a !== 2'b10 || gid_a !== 3'(REQ_DATA)) begin
            n_err++;
            $display("FAIL to_regrant: got wait=%0d ena=%b gid=%0d want wait=24 ena=10 gid=1",
                     k, ena_a, gid_a);
        end
        req_a = 2'b00;
    endtask

    task automatic test_length_guard();
        int hi;
        int errs;
        int bad_d;
        do_reset();
        req_a = 2'b01;
        tick();
        req_a    = 2'b00;
        src_en_a = 2'b01;
        src_d_a  = 8'h05;
        hi = 0; errs = 0; bad_d = 0;
        for (int t = 0; t < 4000; t++) begin
            tick();
            if (tx_en_a === 1'b1) hi++;
            if (err_a === 1'b1) errs++;
            if (tx_en_a === 1'b0 && tx_d_a !== 4'h0) bad_d++;
        end
        src_en_a = 2'b00;
        n_vec++;
        if (hi !== 3100) begin
            n_err++;
            $display("FAIL len_cycles: TX_EN high %0d clocks want 3100", hi);
        end
        n_vec++;
        if (errs !== 1) begin
            n_err++;
            $display("FAIL len_err: %0d err pulses want 1", errs);
        end
        n_vec++;
        if (bad_d !== 0) begin
            n_err++;
            $display("FAIL len_idle_d: TX_D nonzero while idle %0d clocks want 0", bad_d);
        end
        n_vec++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL len_idle: got busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_sclr_mid_send();
        do_reset();
        req_a = 2'b10;
        tick();
        n_vec++;
        if (ena_a !== 2'b10) begin
            n_err++;
            $display("FAIL sclr_grant: got ena=%b want 10", ena_a);
        end
        req_a    = 2'b00;
        src_en_a = 2'b10;
        src_d_a  = 8'h70;
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (tx_en_a !== 1'b1 || gid_a !== 3'd1) begin
            n_err++;
            $display("FAIL sclr_pre: got en=%b gid=%0d want en=1 gid=1", tx_en_a, gid_a);
        end
        sclr = 1'b1;
        tick();
        n_vec++;
        if (tx_en_a !== 1'b0 || tx_d_a !== 4'h0 || busy_a !== 1'b0 || gid_a !== 3'd0) begin
            n_err++;
            $display("FAIL sclr_abort: got en=%b d=%h busy=%b gid=%0d want 0/0/0/0",
                     tx_en_a, tx_d_a, busy_a, gid_a);
        end
        sclr     = 1'b0;
        src_en_a = 2'b00;
        src_d_a  = 8'h00;
        req_a    = 2'b01;
        tick();
        n_vec++;
        if (ena_a !== 2'b01 || gid_a !== 3'd0) begin
            n_err++;
            $display("FAIL sclr_regrant: got ena=%b gid=%0d want ena=01 gid=0", ena_a, gid_a);
        end
        req_a = 2'b00;
    endtask

    initial begin
        sclr = 1'b1;
        req_a = '0; src_en_a = '0; src_d_a = '0;
        req_b = '0; src_en_b = '0; src_d_b = '0;
        sel_req = '0; sel_ptr = '0; sel_mode = 1'b0;
        test_grant_select();
        test_reset();
        test_single_frame();
        test_isolation();
        test_round_robin();
        test_fixed_priority();
        test_start_timeout();
        test_length_guard();
        test_sclr_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mii_tx_arbiter.md
Name: mii_tx_arbiter

Overview:
- Shares the single 4-bit MII transmit port between NUM_REQ frame formers, e.g. the ARP answer former and the ADC data reporter.
- Arbitrates pending requests, issues a one-cycle start pulse to the winner, and muxes its nibble stream onto TX_D/TX_EN.
- Enforces the Ethernet inter-frame gap and guards against stuck or silent formers.
- Runs in the TX_CLK domain, between the formers and the PHY pins.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8. Index 0 is the highest fixed priority.
- RR_MODE, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- IFG_CYCLES, 24: idle clocks between frames (96 bit times at 4 bit/clk).
- START_TIMEOUT, 64: clocks allowed from start pulse to the first src_tx_en.
- MAX_FRAME_CYCLES, 3100: longest legal frame in nibbles, including preamble.

Ports:
- clock  in  1  TX nibble clock (TX_CLK). All logic is on the rising edge.
- sclr  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  level per requester; 1 = frame ready to send.
- ena  out  NUM_REQ  one-hot, one-cycle start pulse to the granted former.
- src_tx_en  in  NUM_REQ  per-former transmit enable.
- src_tx_d  in  4*NUM_REQ  per-former nibble; requester k uses bits [4k+3:4k].
- TX_EN  out  1  registered transmit enable to the PHY.
- TX_D  out  4  registered nibble to the PHY.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last granted requester.
- err_timeout  out  1  one-cycle pulse when a frame is aborted by the start timeout or the length guard.

Behaviour:
- Reset values: ena=0, TX_EN=0, TX_D=0, busy=0, grant_id=0, err_timeout=0. Round-robin pointer = NUM_REQ-1, so requester 0 wins first. FSM goes to IDLE and all counters clear.
- An sclr mid-frame drops TX_EN on the next edge. The truncated frame is not completed.
- IDLE:
  - If any req bit is set, select the winner combinationally.
  - Fixed priority: lowest set index wins.
  - Round-robin: first set index strictly after the pointer, wrapping modulo NUM_REQ.
  - On the next edge: latch grant_id, pulse ena[grant] for exactly one cycle, update the pointer to grant, go to START.
- START:
  - Count clocks. When src_tx_en[grant]=1, go to SEND.
  - If the count reaches START_TIMEOUT first: pulse err_timeout, go to GAP. Nothing is transmitted.
- SEND:
  - Every clock, TX_EN <= src_tx_en[grant] and TX_D <= src_tx_d[grant]. Latency is exactly 1 clock from former to pins.
  - Non-granted formers are ignored. Their tx_en is never forwarded.
  - On the first cycle with src_tx_en[grant]=0, the registered TX_EN goes 0 and the FSM goes to GAP.
  - A frame length counter runs in SEND. On reaching MAX_FRAME_CYCLES: force TX_EN=0, pulse err_timeout, go to GAP, even if the former is still enabled.
- GAP:
  - Hold TX_EN=0 and TX_D=0 for IFG_CYCLES clocks, then go to IDLE.
  - req changes during GAP are only sampled in IDLE.
  - IFG_CYCLES=0 returns to IDLE on the next clock.
- While TX_EN=0, TX_D is driven to 0.
- Simultaneous requests:
  - Round-robin alternates grants between all continuously asserted requesters.
  - Fixed priority can starve higher indices. This is accepted.
- A req that drops before being granted is forgotten. Formers must hold req until their ena pulse.
- ena is never asserted outside the IDLE→START transition. At most one ena bit is ever high.
- A former whose src_tx_en never drops is stopped by the length guard.
- grant_id is held after the frame ends until the next grant.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, START=1, SEND=2, GAP=3.
  - Defaults: IFG_CYCLES=24, MAX_FRAME_CYCLES=3100.
  - Requester index constants: REQ_ARP=0, REQ_DATA=1.
- One sub-module: rr_grant_select. It is a combinational winner-select from req, pointer and RR_MODE, and outputs the grant index and a valid flag. It gets its own unit test.

Test Plan:
- req=2'b01, former 0 raises src_tx_en 3 clocks after ena for 10 clocks with nibbles 1..A:
  - ena[0] pulses 1 cycle.
  - TX_EN is high for 10 clocks, starting 1 clock after src_tx_en.
  - TX_D = 1..A in order.
  - busy falls 24 clocks after TX_EN falls.
- req=2'b11 held, RR_MODE=1, each frame 8 clocks:
  - Grants alternate 0,1,0,1.
  - Exactly 24 idle clocks between frames.
  - With RR_MODE=0, the grant is always 0.
- Granted former never asserts src_tx_en:
  - err_timeout pulses at START_TIMEOUT=64.
  - TX_EN stays 0.
  - The next request is granted after the 24-clock gap.
- Granted former holds src_tx_en for 4000 clocks:
  - TX_EN drops after exactly 3100 clocks.
  - err_timeout pulses once.
- Non-granted former 1 toggles src_tx_en and src_tx_d=F during frame 0 → TX_D shows only former 0 data.
- sclr asserted mid-SEND → next edge TX_EN=0, busy=0, grant_id=0. The next req is granted normally.
